// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice: default sizes, the reserved
// ZERO_REG tag, and the result / broadcast record layouts.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU  = 6;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned FU_ID_W = 3;

    // Tag 0 on the bus means "no broadcast"; FUs never produce it.
    localparam logic [TAG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]  value;
    } FU_RESULT;

    typedef struct packed {
        logic               valid;
        logic [FU_ID_W-1:0] fu_id;
        logic [TAG_W-1:0]   rob_tag;
        logic [XLEN-1:0]    v;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Small per-FU result FIFO with push/pop, occupancy count and a synchronous
// clear that takes priority over both push and pop.
module result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[tail] <= din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push+pop leaves count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[head];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers FU results per unit and broadcasts one
// buffered result per cycle, chosen round-robin across the FUs.
module cdb_arbiter #(
    parameter int unsigned NUM_FU     = cdb_arbiter_pkg::NUM_FU,
    parameter int unsigned SLOT_DEPTH = 2,
    parameter int unsigned XLEN       = cdb_arbiter_pkg::XLEN,
    parameter int unsigned TAG_W      = cdb_arbiter_pkg::TAG_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_rob_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]       fu_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_rob_tag,
    output logic [XLEN-1:0]         cdb_value,
    output logic [2:0]              cdb_fu_id
);

    import cdb_arbiter_pkg::*;

    localparam int unsigned IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned CNT_W = $clog2(SLOT_DEPTH) + 1;
    localparam int unsigned ENT_W = TAG_W + XLEN;

    logic [NUM_FU-1:0]            req;
    logic [NUM_FU-1:0]            grant;
    logic [NUM_FU-1:0]            push;
    logic [NUM_FU-1:0][CNT_W-1:0] count;
    logic [NUM_FU-1:0][ENT_W-1:0] head;
    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             gnt_idx;
    logic                         any_grant;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        result_fifo #(
            .DEPTH (SLOT_DEPTH),
            .WIDTH (ENT_W)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .clear (squash),
            .push  (push[i]),
            .pop   (grant[i]),
            .din   ({fu_rob_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN]}),
            .dout  (head[i]),
            .count (count[i])
        );

        // Only buffered results compete; a full FIFO still accepts while its head drains.
        assign req[i]      = (count[i] != '0);
        assign fu_ready[i] = (count[i] < CNT_W'(SLOT_DEPTH)) | grant[i];
        assign push[i]     = fu_valid[i] & fu_ready[i];
    end

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                   input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        return IDX_W'(s % NUM_FU);
    endfunction

    // Round-robin pick: first requester at or after rr_ptr, with wraparound.
    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        any_grant = 1'b0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (!any_grant && req[wrap_idx(rr_ptr, k)]) begin
                any_grant = 1'b1;
                gnt_idx   = wrap_idx(rr_ptr, k);
            end
        end
        grant[gnt_idx] = any_grant;
    end

    // Priority pointer moves just past the winner; holds when the bus is idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (squash) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Bus drive from the granted FIFO head; all-zero when nothing is buffered.
    always_comb begin
        cdb_valid   = any_grant;
        cdb_rob_tag = TAG_W'(ZERO_REG);
        cdb_value   = '0;
        cdb_fu_id   = '0;
        if (any_grant) begin
            cdb_rob_tag = head[gnt_idx][ENT_W-1 -: TAG_W];
            cdb_value   = head[gnt_idx][XLEN-1:0];
            cdb_fu_id   = 3'(gnt_idx) + 3'd1;
        end
    end

endmodule
